link_packet_scheduler: RTL and testbench

- Wormhole link scheduler that shares one outgoing NIC link among N_REQUEST_SIGNAL input FIFOs.
- Arbitrates round-robin among FIFOs holding a head flit, then locks the link to the winner until its tail flit passes.
- Paces every flit against a downstream credit counter.
- Sits between the input FIFOs and the link; produces the per-flit grant and channel id that drive FIFO pop and the output mux.

---
 rtl/link_packet_scheduler.sv | 121 ++++++++++++
 tb/tb_link_packet_scheduler.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/link_packet_scheduler.sv
// Wormhole link scheduler: round-robin arbitration among FIFOs with a head flit,
// link locked to the winner until its tail flit passes, each flit paced by downstream credits.
module link_packet_scheduler #(
  parameter int N_REQUEST_SIGNAL = 6,
  parameter int N_BITS_POINTER   = $clog2(N_REQUEST_SIGNAL),
  parameter int N_CREDITS        = 4,
  parameter int N_BITS_CREDIT    = $clog2(N_CREDITS + 1)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_REQUEST_SIGNAL-1:0] r_la_i,
  input  logic [N_REQUEST_SIGNAL-1:0] tail_i,
  input  logic                        credit_i,
  output logic                        g_la_o,
  output logic [N_REQUEST_SIGNAL-1:0] g_o,
  output logic [N_BITS_POINTER-1:0]   g_channel_id_o,
  output logic [N_BITS_CREDIT-1:0]    credit_cnt_o,
  output logic                        credit_err_o
);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  localparam logic [N_BITS_CREDIT-1:0]  CREDIT_FULL = N_BITS_CREDIT'(N_CREDITS);
  localparam logic [N_BITS_POINTER-1:0] LAST_CHAN   = N_BITS_POINTER'(N_REQUEST_SIGNAL - 1);

  state_t                    r_state, w_state_next;
  logic [N_BITS_POINTER-1:0] r_owner, w_owner_next;
  logic [N_BITS_POINTER-1:0] r_last_winner, w_last_winner_next;
  logic [N_BITS_POINTER-1:0] w_winner;
  logic [N_BITS_CREDIT-1:0]  r_credit_cnt, w_credit_cnt_next;
  logic                      r_credit_err, w_credit_err_next;
  logic                      w_any_req;
  logic                      w_has_credit;
  logic                      w_grant;
  int                        w_idx;

  // Scan offsets from high to low so the closest requester after last_winner wins.
  always_comb begin
    w_winner  = r_last_winner;
    w_any_req = |r_la_i;
    w_idx     = 0;
    for (int k = N_REQUEST_SIGNAL - 1; k >= 0; k--) begin
      w_idx = (int'(r_last_winner) + 1 + k) % N_REQUEST_SIGNAL;
      if (r_la_i[N_BITS_POINTER'(w_idx)]) begin
        w_winner = N_BITS_POINTER'(w_idx);
      end
    end
  end

  assign w_has_credit = (r_credit_cnt != '0);
  // Gated by rst so a reset cycle never pops a FIFO.
  assign w_grant = rst && (r_state == LOCKED) && r_la_i[r_owner] && w_has_credit;

  always_comb begin
    w_state_next       = r_state;
    w_owner_next       = r_owner;
    w_last_winner_next = r_last_winner;
    case (r_state)
      IDLE: begin
        if (w_any_req && w_has_credit) begin
          w_owner_next = w_winner;
          w_state_next = LOCKED;
        end
      end
      LOCKED: begin
        if (w_grant && tail_i[r_owner]) begin
          w_state_next       = IDLE;
          w_last_winner_next = r_owner;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    w_credit_cnt_next = r_credit_cnt;
    w_credit_err_next = r_credit_err;
    case ({w_grant, credit_i})
      2'b10: w_credit_cnt_next = r_credit_cnt - 1'b1;
      2'b01: begin
        if (r_credit_cnt == CREDIT_FULL) begin
          w_credit_err_next = 1'b1;
        end else begin
          w_credit_cnt_next = r_credit_cnt + 1'b1;
        end
      end
      default: w_credit_cnt_next = r_credit_cnt;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state       <= IDLE;
      r_owner       <= '0;
      r_last_winner <= LAST_CHAN;
      r_credit_cnt  <= CREDIT_FULL;
      r_credit_err  <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_owner       <= w_owner_next;
      r_last_winner <= w_last_winner_next;
      r_credit_cnt  <= w_credit_cnt_next;
      r_credit_err  <= w_credit_err_next;
    end
  end

  generate
    for (genvar gi = 0; gi < N_REQUEST_SIGNAL; gi++) begin : g_pop
      assign g_o[gi] = w_grant && (r_owner == N_BITS_POINTER'(gi));
    end
  endgenerate

  assign g_la_o         = w_grant;
  assign g_channel_id_o = r_owner;
  assign credit_cnt_o   = r_credit_cnt;
  assign credit_err_o   = r_credit_err;

endmodule

// File: tb/tb_link_packet_scheduler.sv
// Directed bench for link_packet_scheduler: inputs driven on falling edge, outputs checked 1 time unit later.
module tb_link_packet_scheduler;

  logic       clk;
  logic       rst;
  logic [5:0] r_la_i;
  logic [5:0] tail_i;
  logic       credit_i;
  logic       g_la_o;
  logic [5:0] g_o;
  logic [2:0] g_channel_id_o;
  logic [2:0] credit_cnt_o;
  logic       credit_err_o;

  int checks = 0;
  int errors = 0;

  link_packet_scheduler dut (
    .clk            (clk),
    .rst            (rst),
    .r_la_i         (r_la_i),
    .tail_i         (tail_i),
    .credit_i       (credit_i),
    .g_la_o         (g_la_o),
    .g_o            (g_o),
    .g_channel_id_o (g_channel_id_o),
    .credit_cnt_o   (credit_cnt_o),
    .credit_err_o   (credit_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Leaves rst released at a falling edge with the DUT in its reset state.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; r_la_i = '0; tail_i = '0; credit_i = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++; if (g_la_o !== 1'b0) begin errors++; $display("FAIL reset g_la got %b exp 0", g_la_o); end
    checks++; if (g_o !== 6'b0) begin errors++; $display("FAIL reset g_o got %b exp 000000", g_o); end
    checks++; if (g_channel_id_o !== 3'd0) begin errors++; $display("FAIL reset id got %0d exp 0", g_channel_id_o); end
    checks++; if (credit_cnt_o !== 3'd4) begin errors++; $display("FAIL reset cnt got %0d exp 4", credit_cnt_o); end
    checks++; if (credit_err_o !== 1'b0) begin errors++; $display("FAIL reset err got %b exp 0", credit_err_o); end
    $display("test_reset done");
  endtask

  task automatic test_round_robin();
    logic       eg;
    logic [2:0] eid;
    do_reset();
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      r_la_i = 6'b111111; tail_i = 6'b111111; credit_i = 1'b1;
      #1;
      eg  = (c % 2) == 1;
      eid = 3'((c / 2) % 6);
      checks++; if (g_la_o !== eg) begin errors++; $display("FAIL rr cyc %0d g_la got %b exp %b", c, g_la_o, eg); end
      checks++; if (credit_cnt_o !== 3'd4) begin errors++; $display("FAIL rr cyc %0d cnt got %0d exp 4", c, credit_cnt_o); end
      if (eg) begin
        checks++; if (g_channel_id_o !== eid) begin errors++; $display("FAIL rr cyc %0d id got %0d exp %0d", c, g_channel_id_o, eid); end
        checks++; if (g_o !== (6'b1 << eid)) begin errors++; $display("FAIL rr cyc %0d g_o got %b exp %b", c, g_o, 6'b1 << eid); end
      end else begin
        checks++; if (g_o !== 6'b0) begin errors++; $display("FAIL rr cyc %0d g_o got %b exp 000000", c, g_o); end
      end
      $display("rr cyc %0d g_la=%b id=%0d cnt=%0d", c, g_la_o, g_channel_id_o, credit_cnt_o);
    end
    checks++; if (credit_err_o !== 1'b1) begin errors++; $display("FAIL rr err got %b exp 1", credit_err_o); end
  endtask

  // Shared table-walker body is duplicated per task on purpose: each scenario keeps its own tables.
  task automatic test_wormhole();
    logic [5:0] req [6] = '{6'b000100, 6'b000100, 6'b100100, 6'b100100, 6'b100000, 6'b100000};
    logic [5:0] tl  [6] = '{6'b000000, 6'b000000, 6'b000000, 6'b000100, 6'b000000, 6'b100000};
    logic       eg  [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [2:0] eid [6] = '{3'd0, 3'd2, 3'd2, 3'd2, 3'd0, 3'd5};
    logic [2:0] ec  [6] = '{3'd4, 3'd4, 3'd3, 3'd2, 3'd1, 3'd1};
    do_reset();
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      r_la_i = req[c]; tail_i = tl[c]; credit_i = 1'b0;
      #1;
      checks++; if (g_la_o !== eg[c]) begin errors++; $display("FAIL worm cyc %0d g_la got %b exp %b", c, g_la_o, eg[c]); end
      checks++; if (credit_cnt_o !== ec[c]) begin errors++; $display("FAIL worm cyc %0d cnt got %0d exp %0d", c, credit_cnt_o, ec[c]); end
      if (eg[c]) begin
        checks++; if (g_channel_id_o !== eid[c]) begin errors++; $display("FAIL worm cyc %0d id got %0d exp %0d", c, g_channel_id_o, eid[c]); end
        checks++; if (g_o !== (6'b1 << eid[c])) begin errors++; $display("FAIL worm cyc %0d g_o got %b", c, g_o); end
      end
      $display("worm cyc %0d g_la=%b id=%0d cnt=%0d", c, g_la_o, g_channel_id_o, credit_cnt_o);
    end
  endtask

  task automatic test_credits();
    logic       cr [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic       eg [9] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [2:0] ec [9] = '{3'd4, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd0, 3'd1, 3'd0};
    do_reset();
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      r_la_i = 6'b000010; tail_i = 6'b0; credit_i = cr[c];
      #1;
      checks++; if (g_la_o !== eg[c]) begin errors++; $display("FAIL cred cyc %0d g_la got %b exp %b", c, g_la_o, eg[c]); end
      checks++; if (credit_cnt_o !== ec[c]) begin errors++; $display("FAIL cred cyc %0d cnt got %0d exp %0d", c, credit_cnt_o, ec[c]); end
      if (eg[c]) begin
        checks++; if (g_o !== 6'b000010) begin errors++; $display("FAIL cred cyc %0d g_o got %b exp 000010", c, g_o); end
      end else begin
        checks++; if (g_o !== 6'b0) begin errors++; $display("FAIL cred cyc %0d g_o got %b exp 000000", c, g_o); end
      end
      $display("cred cyc %0d g_la=%b cnt=%0d", c, g_la_o, credit_cnt_o);
    end
  endtask

  task automatic test_stall();
    logic [5:0] req [8] = '{6'b001000, 6'b001000, 6'b000001, 6'b000001, 6'b001001, 6'b001001, 6'b000001, 6'b000001};
    logic [5:0] tl  [8] = '{6'b000000, 6'b000000, 6'b000000, 6'b000000, 6'b000000, 6'b001000, 6'b000000, 6'b000001};
    logic       eg  [8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [2:0] eid [8] = '{3'd0, 3'd3, 3'd3, 3'd3, 3'd3, 3'd3, 3'd0, 3'd0};
    logic [2:0] ec  [8] = '{3'd4, 3'd4, 3'd3, 3'd3, 3'd3, 3'd2, 3'd1, 3'd1};
    do_reset();
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      r_la_i = req[c]; tail_i = tl[c]; credit_i = 1'b0;
      #1;
      checks++; if (g_la_o !== eg[c]) begin errors++; $display("FAIL stall cyc %0d g_la got %b exp %b", c, g_la_o, eg[c]); end
      checks++; if (credit_cnt_o !== ec[c]) begin errors++; $display("FAIL stall cyc %0d cnt got %0d exp %0d", c, credit_cnt_o, ec[c]); end
      if (c >= 1 && c <= 5) begin
        checks++; if (g_channel_id_o !== eid[c]) begin errors++; $display("FAIL stall cyc %0d id got %0d exp %0d", c, g_channel_id_o, eid[c]); end
      end
      if (eg[c]) begin
        checks++; if (g_o !== (6'b1 << eid[c])) begin errors++; $display("FAIL stall cyc %0d g_o got %b", c, g_o); end
      end else begin
        checks++; if (g_o !== 6'b0) begin errors++; $display("FAIL stall cyc %0d g_o got %b exp 000000", c, g_o); end
      end
      $display("stall cyc %0d g_la=%b id=%0d cnt=%0d", c, g_la_o, g_channel_id_o, credit_cnt_o);
    end
  endtask

  task automatic test_credit_err();
    logic cr [3] = '{1'b1, 1'b0, 1'b0};
    logic ee [3] = '{1'b0, 1'b1, 1'b1};
    do_reset();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      r_la_i = 6'b0; tail_i = 6'b0; credit_i = cr[c];
      #1;
      checks++; if (credit_err_o !== ee[c]) begin errors++; $display("FAIL err cyc %0d err got %b exp %b", c, credit_err_o, ee[c]); end
      checks++; if (credit_cnt_o !== 3'd4) begin errors++; $display("FAIL err cyc %0d cnt got %0d exp 4", c, credit_cnt_o); end
      $display("err cyc %0d err=%b cnt=%0d", c, credit_err_o, credit_cnt_o);
    end
    do_reset();
    #1;
    checks++; if (credit_err_o !== 1'b0) begin errors++; $display("FAIL err after reset got %b exp 0", credit_err_o); end
  endtask

  task automatic test_reset_mid_packet();
    do_reset();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      r_la_i = 6'b010000; tail_i = 6'b0; credit_i = 1'b0;
    end
    #1;
    checks++; if (g_la_o !== 1'b1 || g_channel_id_o !== 3'd4) begin errors++; $display("FAIL midrst locked got g_la=%b id=%0d exp 1/4", g_la_o, g_channel_id_o); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (g_la_o !== 1'b0) begin errors++; $display("FAIL midrst during reset g_la got %b exp 0", g_la_o); end
    @(negedge clk);
    rst = 1'b1; r_la_i = 6'b111111; tail_i = 6'b111111;
    #1;
    checks++; if (g_la_o !== 1'b0) begin errors++; $display("FAIL midrst after g_la got %b exp 0", g_la_o); end
    checks++; if (credit_cnt_o !== 3'd4) begin errors++; $display("FAIL midrst after cnt got %0d exp 4", credit_cnt_o); end
    @(negedge clk);
    #1;
    checks++; if (g_la_o !== 1'b1) begin errors++; $display("FAIL midrst rearb g_la got %b exp 1", g_la_o); end
    checks++; if (g_channel_id_o !== 3'd0) begin errors++; $display("FAIL midrst rearb id got %0d exp 0", g_channel_id_o); end
    $display("midrst rearb g_la=%b id=%0d cnt=%0d", g_la_o, g_channel_id_o, credit_cnt_o);
  endtask

  initial begin
    rst = 1'b0; r_la_i = '0; tail_i = '0; credit_i = 1'b0;
    test_reset();
    test_round_robin();
    test_wormhole();
    test_credits();
    test_stall();
    test_credit_err();
    test_reset_mid_packet();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
